// File: rtl/piso_serial_tx_pkg.sv
// ---------------------------------------------------------------------------
// piso_serial_tx_pkg
// Shared definitions for the parallel-in/serial-out transmitter and its
// matching receiver-side deserializer.
//   state_t : FSM state encoding (ST_IDLE = 1'b0, ST_SHIFT = 1'b1)
//   cnt_w() : width of a mod-WIDTH bit counter (never narrower than 1 bit)
// ---------------------------------------------------------------------------
package piso_serial_tx_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    function automatic int cnt_w(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// ---------------------------------------------------------------------------
// piso_bit_counter
// Mod-WIDTH bit counter with synchronous clear, enable and terminal count.
//   clk    : clock, rising edge
//   rst    : asynchronous active-high reset, count -> 0
//   clear  : force count to 0 on the next edge (wins over enable)
//   enable : advance count by one; wraps explicitly from WIDTH-1 to 0
//   count  : current count, 0 .. WIDTH-1
//   last   : count == WIDTH-1
// ---------------------------------------------------------------------------
module piso_bit_counter
    import piso_serial_tx_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  logic                    enable,
    output logic [cnt_w(WIDTH)-1:0] count,
    output logic                    last
);

    localparam int CNT_W = cnt_w(WIDTH);
    localparam logic [CNT_W-1:0] LAST_VAL = CNT_W'(WIDTH - 1);

    logic [CNT_W-1:0] count_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (enable) begin
            if (count_reg == LAST_VAL) begin
                count_reg <= '0;
            end else begin
                count_reg <= count_reg + 1'b1;
            end
        end
    end

    assign count = count_reg;
    assign last  = (count_reg == LAST_VAL);

endmodule

// File: rtl/piso_serial_tx.sv
// ---------------------------------------------------------------------------
// piso_serial_tx
// Parallel-in/serial-out transmitter. A WIDTH-bit word is accepted through a
// valid/ready handshake and sent one bit per clock on d_out, framed by frame,
// with done marking the last bit of each word.
//   clk        : clock, all state changes on rising edge
//   rst        : asynchronous active-high reset
//   load_valid : producer offers data_in
//   load_ready : word can be accepted this cycle (combinational)
//   data_in    : parallel word, captured on load_valid && load_ready
//   d_out      : registered serial bit
//   d_out_n    : registered complement of d_out
//   frame      : high while d_out carries a valid bit
//   done       : high during the last bit of a word
// ---------------------------------------------------------------------------
module piso_serial_tx
    import piso_serial_tx_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] data_in,
    output logic             d_out,
    output logic             d_out_n,
    output logic             frame,
    output logic             done
);

    localparam int CNT_W = cnt_w(WIDTH);

    state_t           state_reg;
    state_t           state_next;
    logic [WIDTH-1:0] shift_reg;
    logic             d_out_reg;
    logic             d_out_n_reg;
    logic             frame_reg;
    logic [CNT_W-1:0] count;
    logic             last;
    logic             load_fire;
    logic             in_shift;

    // Bit-order selection: "head" is the bit transmitted next, "tail" is the
    // word with that bit removed, aligned so the following bit becomes head.
    logic             load_head;
    logic [WIDTH-1:0] load_tail;
    logic             reg_head;
    logic [WIDTH-1:0] reg_tail;

    generate
        if (MSB_FIRST) begin : g_msb_first
            assign load_head = data_in[WIDTH-1];
            assign load_tail = data_in << 1;
            assign reg_head  = shift_reg[WIDTH-1];
            assign reg_tail  = shift_reg << 1;
        end else begin : g_lsb_first
            assign load_head = data_in[0];
            assign load_tail = data_in >> 1;
            assign reg_head  = shift_reg[0];
            assign reg_tail  = shift_reg >> 1;
        end
    endgenerate

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next state and handshake
    always_comb begin
        state_next = state_reg;
        load_ready = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                load_ready = 1'b1;
                if (load_valid) begin
                    state_next = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                // The last-bit cycle doubles as a load slot so words can
                // stream back-to-back without a frame gap.
                if (last) begin
                    load_ready = 1'b1;
                    state_next = load_valid ? ST_SHIFT : ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign load_fire = load_valid && load_ready;
    assign in_shift  = (state_reg == ST_SHIFT);

    // Output and shift datapath. The first bit goes straight to d_out at the
    // capturing edge, so shift_reg only holds the bits still to come.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_reg   <= '0;
            d_out_reg   <= 1'b0;
            d_out_n_reg <= 1'b1;
            frame_reg   <= 1'b0;
        end else if (load_fire) begin
            shift_reg   <= load_tail;
            d_out_reg   <= load_head;
            d_out_n_reg <= ~load_head;
            frame_reg   <= 1'b1;
        end else if (in_shift) begin
            if (last) begin
                shift_reg   <= '0;
                d_out_reg   <= 1'b0;
                d_out_n_reg <= 1'b1;
                frame_reg   <= 1'b0;
            end else begin
                shift_reg   <= reg_tail;
                d_out_reg   <= reg_head;
                d_out_n_reg <= ~reg_head;
            end
        end
    end

    // Counter tracks which bit is on d_out; cleared on every load and when
    // the frame ends so IDLE always sits at zero.
    piso_bit_counter #(
        .WIDTH (WIDTH)
    ) u_bit_counter (
        .clk    (clk),
        .rst    (rst),
        .clear  (load_fire || (in_shift && last)),
        .enable (in_shift && !last),
        .count  (count),
        .last   (last)
    );

    assign d_out   = d_out_reg;
    assign d_out_n = d_out_n_reg;
    assign frame   = frame_reg;
    assign done    = in_shift && last;

endmodule

// File: tb/tb_piso_serial_tx.sv
// ---------------------------------------------------------------------------
// tb_piso_serial_tx
// Directed bench for piso_serial_tx. Two instances share all inputs: one
// MSB-first, one LSB-first. Outputs are sampled 1 ns after each rising edge.
// ---------------------------------------------------------------------------
module tb_piso_serial_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic       load_valid;
    logic [7:0] data_in;

    logic m_ready, m_d, m_dn, m_frame, m_done;
    logic l_ready, l_d, l_dn, l_frame, l_done;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    piso_serial_tx #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_msb (
        .clk        (clk),
        .rst        (rst),
        .load_valid (load_valid),
        .load_ready (m_ready),
        .data_in    (data_in),
        .d_out      (m_d),
        .d_out_n    (m_dn),
        .frame      (m_frame),
        .done       (m_done)
    );

    piso_serial_tx #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
        .clk        (clk),
        .rst        (rst),
        .load_valid (load_valid),
        .load_ready (l_ready),
        .data_in    (data_in),
        .d_out      (l_d),
        .d_out_n    (l_dn),
        .frame      (l_frame),
        .done       (l_done)
    );

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Check the four outputs of the MSB-first instance for one bit cycle.
    task automatic chk_m(input string tag, input int i, input logic b, input logic dn);
        chk($sformatf("%s_d%0d", tag, i),     m_d,     b);
        chk($sformatf("%s_dn%0d", tag, i),    m_dn,    ~b);
        chk($sformatf("%s_frame%0d", tag, i), m_frame, 1'b1);
        chk($sformatf("%s_done%0d", tag, i),  m_done,  dn);
        $display("%s bit %0d: d_out=%b frame=%b done=%b", tag, i, m_d, m_frame, m_done);
    endtask

    task automatic chk_m_idle(input string tag);
        chk({tag, "_idle_frame"}, m_frame, 1'b0);
        chk({tag, "_idle_d"},     m_d,     1'b0);
        chk({tag, "_idle_dn"},    m_dn,    1'b1);
        chk({tag, "_idle_ready"}, m_ready, 1'b1);
    endtask

    initial begin
        logic [7:0] w;

        rst        = 1'b1;
        load_valid = 1'b0;
        data_in    = 8'h00;
        step();
        step();
        rst = 1'b0;
        step();

        // Reset / idle state
        chk("rst_d",     m_d,     1'b0);
        chk("rst_dn",    m_dn,    1'b1);
        chk("rst_frame", m_frame, 1'b0);
        chk("rst_done",  m_done,  1'b0);
        chk("rst_ready", m_ready, 1'b1);

        // Basic MSB-first: 8'hA5
        w          = 8'hA5;
        data_in    = w;
        load_valid = 1'b1;
        step();
        load_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk_m("a5", i, w[7-i], i == 7);
            step();
        end
        chk_m_idle("a5");

        // LSB-first: 8'h01 on the LSB instance
        w          = 8'h01;
        data_in    = w;
        load_valid = 1'b1;
        step();
        load_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("lsb_d%0d", i),     l_d,     w[i]);
            chk($sformatf("lsb_dn%0d", i),    l_dn,    ~w[i]);
            chk($sformatf("lsb_frame%0d", i), l_frame, 1'b1);
            chk($sformatf("lsb_done%0d", i),  l_done,  i == 7);
            $display("lsb bit %0d: d_out=%b done=%b", i, l_d, l_done);
            step();
        end
        chk("lsb_idle_frame", l_frame, 1'b0);
        chk("lsb_idle_d",     l_d,     1'b0);

        // Back-to-back: 8'hFF then 8'h00 accepted on the last-bit cycle
        data_in    = 8'hFF;
        load_valid = 1'b1;
        step();
        data_in = 8'h00;
        for (int i = 0; i < 16; i++) begin
            chk_m("b2b", i, i < 8, (i == 7) || (i == 15));
            chk($sformatf("b2b_ready%0d", i), m_ready, (i == 7) || (i == 15));
            step();
            if (i == 7) load_valid = 1'b0;
        end
        chk_m_idle("b2b");

        // Ignored load during bit 3 of 8'hA5
        w          = 8'hA5;
        data_in    = w;
        load_valid = 1'b1;
        step();
        load_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i == 3) begin
                data_in    = 8'h3C;
                load_valid = 1'b1;
                chk("ign_ready", m_ready, 1'b0);
            end
            chk_m("ign", i, w[7-i], i == 7);
            step();
            if (i == 3) load_valid = 1'b0;
        end
        chk_m_idle("ign");
        step();
        chk("ign_no_tx_frame", m_frame, 1'b0);

        // Async reset mid-frame, then held with load_valid=1
        w          = 8'hA5;
        data_in    = w;
        load_valid = 1'b1;
        step();
        load_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk_m("ar", i, w[7-i], 1'b0);
            if (i < 3) step();
        end
        #2;
        rst = 1'b1;
        #1;
        chk("ar_d",     m_d,     1'b0);
        chk("ar_dn",    m_dn,    1'b1);
        chk("ar_frame", m_frame, 1'b0);
        chk("ar_done",  m_done,  1'b0);
        $display("async rst: d_out=%b d_out_n=%b frame=%b", m_d, m_dn, m_frame);
        w          = 8'h81;
        data_in    = w;
        load_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            chk($sformatf("rh_d%0d", c),     m_d,     1'b0);
            chk($sformatf("rh_dn%0d", c),    m_dn,    1'b1);
            chk($sformatf("rh_frame%0d", c), m_frame, 1'b0);
            chk($sformatf("rh_done%0d", c),  m_done,  1'b0);
        end
        rst = 1'b0;
        step();
        load_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk_m("x81", i, w[7-i], i == 7);
            step();
        end
        chk_m_idle("x81");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
